multi_tick_gen: RTL and testbench

Parametrised multi-channel tick and strobe generator. It replaces the fixed single-period divider in the VGA_Brush clocking path. Each of NUM_CH channels has its own runtime-programmable period and phase, and runs in either periodic or one-shot mode. Each channel produces a one-cycle pulse and a ~50% square wave. New configurations are applied glitch-free at period boundaries through a valid/ready configuration port.

---
 rtl/multi_tick_gen.sv | 114 +++++++++++
 tb/tb_multi_tick_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_tick_gen.sv
// rtl/multi_tick_gen.sv - multi-channel programmable tick, strobe and square-wave generator
module multi_tick_gen #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 500000,
  parameter int DEFAULT_PHASE  = 299999,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Origin_Clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic [CNT_W-1:0]  cfg_phase,
  input  logic              cfg_mode,
  output logic [NUM_CH-1:0] pulse,
  output logic [NUM_CH-1:0] square,
  output logic [NUM_CH-1:0] busy
);

  localparam logic [CNT_W-1:0] DEF_PER  = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_PH   = CNT_W'(DEFAULT_PHASE);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);

  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [CNT_W-1:0]  period [NUM_CH];
  logic [CNT_W-1:0]  phase  [NUM_CH];
  logic [NUM_CH-1:0] mode;
  logic [NUM_CH-1:0] done;

  logic              pending;
  logic [CH_W-1:0]   slot_ch;
  logic [CNT_W-1:0]  slot_period;
  logic [CNT_W-1:0]  slot_phase;
  logic              slot_mode;

  logic [NUM_CH-1:0] at_end;
  logic [NUM_CH-1:0] apply;
  logic [NUM_CH-1:0] fire;
  logic              slot_bad;

  assign cfg_ready = ~pending;

  // A pending slot lands only where the target channel cannot be mid-period:
  // at its wrap, while disabled, or after a one-shot has fired.
  always_comb begin
    slot_bad = pending & ({1'b0, slot_ch} >= CH_LIMIT);
    for (int i = 0; i < NUM_CH; i++) begin
      at_end[i] = count[i] >= (period[i] - ONE);
      apply[i]  = pending & (slot_ch == CH_W'(i)) & (~ch_en[i] | done[i] | at_end[i]);
      fire[i]   = ch_en[i] & ~done[i] & (count[i] == phase[i]);
      pulse[i]  = ~reset & fire[i];
      square[i] = ~reset & ch_en[i] & ~done[i] & (count[i] < (period[i] >> 1));
      busy[i]   = ~reset & ch_en[i] & mode[i] & ~done[i];
    end
  end

  always_ff @(posedge Origin_Clock or posedge reset) begin
    if (reset) begin
      pending     <= 1'b0;
      slot_ch     <= '0;
      slot_period <= TWO;
      slot_phase  <= '0;
      slot_mode   <= 1'b0;
      mode        <= '0;
      done        <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count[i]  <= '0;
        period[i] <= DEF_PER;
        phase[i]  <= DEF_PH;
      end
    end else begin
      if (!pending) begin
        if (cfg_valid) begin
          pending     <= 1'b1;
          slot_ch     <= cfg_ch;
          slot_period <= (cfg_period < TWO) ? TWO : cfg_period;
          slot_phase  <= cfg_phase;
          slot_mode   <= cfg_mode;
        end
      end else if (slot_bad || (|apply)) begin
        pending <= 1'b0;
      end

      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          period[i] <= slot_period;
          phase[i]  <= slot_phase;
          mode[i]   <= slot_mode;
          count[i]  <= '0;
          done[i]   <= 1'b0;
        end else if (!ch_en[i]) begin
          count[i]  <= '0;
          done[i]   <= 1'b0;
        end else begin
          if (sync_clr) begin
            count[i] <= '0;
          end else if (!done[i]) begin
            count[i] <= at_end[i] ? '0 : count[i] + ONE;
          end
          if (fire[i] && mode[i]) begin
            done[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_tick_gen.sv
// tb/tb_multi_tick_gen.sv - directed self-checking bench for multi_tick_gen
module tb_multi_tick_gen;

  localparam int NUM_CH = 5;
  localparam int CNT_W  = 16;
  localparam int CH_W   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync_clr = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_period = '0;
  logic [CNT_W-1:0]  cfg_phase = '0;
  logic              cfg_mode = 1'b0;
  logic [NUM_CH-1:0] pulse;
  logic [NUM_CH-1:0] square;
  logic [NUM_CH-1:0] busy;

  int n_checks = 0;
  int n_fail   = 0;

  multi_tick_gen #(
    .NUM_CH(NUM_CH),
    .CNT_W(CNT_W),
    .DEFAULT_PERIOD(50),
    .DEFAULT_PHASE(29)
  ) dut (
    .Origin_Clock(clk),
    .reset(reset),
    .ch_en(ch_en),
    .sync_clr(sync_clr),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_period(cfg_period),
    .cfg_phase(cfg_phase),
    .cfg_mode(cfg_mode),
    .pulse(pulse),
    .square(square),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int ch, input int per, input int ph, input logic md);
    cfg_valid  = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_period = CNT_W'(per);
    cfg_phase  = CNT_W'(ph);
    cfg_mode   = md;
  endtask

  initial begin
    // reset held with a channel enabled: everything quiet
    ch_en = 5'b00001;
    #2;
    check_eq("rst_pulse", 32'(pulse), 32'(0));
    check_eq("rst_square", 32'(square), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_ready", 32'(cfg_ready), 32'(1));
    step(2);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 130; k++) begin
      check_eq("default_ch0", 32'({pulse[0], square[0]}), 32'({k % 50 == 29, k % 50 < 25}));
      step(1);
    end
    ch_en = '0;
    step(1);

    // ch1 reconfigured while running the default period
    ch_en = 5'b00010;
    send_cfg(1, 10, 3, 1'b0);
    #1;
    check_eq("t2_ready_pre", 32'(cfg_ready), 32'(1));
    step(1);
    cfg_valid = 1'b0;
    check_eq("t2_ready_acc", 32'(cfg_ready), 32'(0));
    step(47);
    check_eq("t2_ready_hold", 32'(cfg_ready), 32'(0));
    step(1);
    check_eq("t2_ready_last", 32'(cfg_ready), 32'(0));
    step(1);
    check_eq("t2_ready_apply", 32'(cfg_ready), 32'(1));
    for (int j = 0; j < 30; j++) begin
      check_eq("t2_ch1", 32'({pulse[1], square[1]}), 32'({j % 10 == 3, j % 10 < 5}));
      step(1);
    end
    ch_en = '0;
    step(1);

    // ch2: period 10 phase 7, then retarget mid-period to period 6 phase 0
    send_cfg(2, 10, 7, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    ch_en = 5'b00100;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("t3_old", 32'({cfg_ready, pulse[2], square[2]}), 32'({1'b1, k == 7, k < 5}));
      step(1);
    end
    send_cfg(2, 6, 0, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    for (int m = 0; m < 5; m++) begin
      check_eq("t3_finish", 32'({cfg_ready, pulse[2], square[2]}), 32'({1'b0, (5 + m) == 7, (5 + m) < 5}));
      step(1);
    end
    for (int j = 0; j < 18; j++) begin
      check_eq("t3_new", 32'({cfg_ready, pulse[2], square[2]}), 32'({1'b1, j % 6 == 0, j % 6 < 3}));
      step(1);
    end
    ch_en = '0;
    step(1);

    // ch3 one-shot, then re-arm by toggling its enable
    send_cfg(3, 8, 5, 1'b1);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    ch_en = 5'b01000;
    #1;
    for (int k = 0; k < 20; k++) begin
      check_eq("t4_shot", 32'({busy[3], pulse[3], square[3]}),
               (k <= 5) ? 32'({1'b1, k == 5, k < 4}) : 32'(0));
      step(1);
    end
    ch_en = '0;
    #1;
    check_eq("t4_off", 32'(busy), 32'(0));
    step(1);
    ch_en = 5'b01000;
    #1;
    for (int k = 0; k < 10; k++) begin
      check_eq("t4_rearm", 32'({busy[3], pulse[3], square[3]}),
               (k <= 5) ? 32'({1'b1, k == 5, k < 4}) : 32'(0));
      step(1);
    end
    ch_en = '0;
    step(1);

    // period 0 is stored as 2
    send_cfg(0, 0, 1, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    ch_en = 5'b00001;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq("t5_per0", 32'({pulse[0], square[0]}), 32'({k % 2 == 1, k % 2 == 0}));
      step(1);
    end

    // phase beyond period: square only
    ch_en = '0;
    send_cfg(0, 10, 12, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    step(1);
    ch_en = 5'b00001;
    #1;
    for (int k = 0; k < 25; k++) begin
      check_eq("t5_phase_big", 32'({pulse[0], square[0]}), 32'({1'b0, k % 10 < 5}));
      step(1);
    end

    // out-of-range channel is accepted then dropped
    ch_en = '0;
    send_cfg(7, 3, 1, 1'b0);
    #1;
    check_eq("t5_bad_pre", 32'(cfg_ready), 32'(1));
    step(1);
    cfg_valid = 1'b0;
    check_eq("t5_bad_pend", 32'(cfg_ready), 32'(0));
    step(1);
    check_eq("t5_bad_drop", 32'(cfg_ready), 32'(1));
    ch_en = 5'b00001;
    #1;
    for (int k = 0; k < 12; k++) begin
      check_eq("t5_bad_keep", 32'({pulse[0], square[0]}), 32'({1'b0, k % 10 < 5}));
      step(1);
    end
    ch_en = '0;
    step(1);

    // second request while pending is held off; first one applies
    ch_en = 5'b00010;
    send_cfg(1, 4, 1, 1'b0);
    #1;
    step(1);
    send_cfg(1, 6, 2, 1'b0);
    check_eq("t5_second_busy", 32'(cfg_ready), 32'(0));
    step(8);
    check_eq("t5_second_hold", 32'(cfg_ready), 32'(0));
    step(1);
    cfg_valid = 1'b0;
    check_eq("t5_second_ready", 32'(cfg_ready), 32'(1));
    for (int k = 0; k < 8; k++) begin
      check_eq("t5_first_wins", 32'({pulse[1], square[1]}), 32'({k % 4 == 1, k % 4 < 2}));
      step(1);
    end
    ch_en = '0;
    step(1);

    // sync_clr with ch0 at count 7 and ch2 at count 1
    ch_en = 5'b00101;
    step(7);
    check_eq("t6_pre", 32'({pulse[2], square[2], square[0]}), 32'(3'b010));
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check_eq("t6_clr", 32'({pulse[2], square[2], square[0]}),
               32'({k % 6 == 0, k % 6 < 3, k % 10 < 5}));
      step(1);
    end

    // asynchronous reset mid-count with a config pending
    ch_en = 5'b00001;
    step(1);
    send_cfg(0, 4, 0, 1'b0);
    step(1);
    cfg_valid = 1'b0;
    check_eq("t7_pend", 32'(cfg_ready), 32'(0));
    #3;
    reset = 1'b1;
    #1;
    check_eq("t7_rst_pulse", 32'(pulse), 32'(0));
    check_eq("t7_rst_square", 32'(square), 32'(0));
    check_eq("t7_rst_busy", 32'(busy), 32'(0));
    check_eq("t7_rst_ready", 32'(cfg_ready), 32'(1));
    step(2);
    reset = 1'b0;
    #1;
    for (int k = 0; k < 60; k++) begin
      check_eq("t7_defaults", 32'({cfg_ready, pulse[0], square[0]}),
               32'({1'b1, k % 50 == 29, k % 50 < 25}));
      step(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
